// File: rtl/flopr_pipe.sv
// Elastic pipeline register: STAGES flop stages with per-stage valid,
// valid/ready handshake on both ends, bubble collapse and flush.
module flopr_pipe #(
  parameter int N      = 64,
  parameter int STAGES = 3,
  localparam int OW    = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  q,
  output logic [OW-1:0] occupancy
);

  logic [STAGES-1:0] v_q, v_d;
  logic [N-1:0]      data_q [STAGES];
  logic [N-1:0]      data_d [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES:0]   src_v;
  logic [N-1:0]      src_data [STAGES+1];
  logic [OW-1:0]     cnt;

  // Ready ripples from the output side; an empty stage is always ready.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  // Source of each stage: slot 0 is the upstream port.
  always_comb begin
    src_v = '0;
    src_v[0] = in_valid;
    src_data[0] = d;
    for (int i = 0; i < STAGES; i++) begin
      src_v[i+1] = v_q[i];
      src_data[i+1] = data_q[i];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        data_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          v_d[i] = src_v[i];
          if (src_v[i]) begin
            data_d[i] = src_data[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + OW'(v_q[i]);
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[STAGES-1];
  assign q         = data_q[STAGES-1];
  assign occupancy = cnt;

endmodule

// File: tb/tb_flopr_pipe.sv
// Scoreboard bench for flopr_pipe: default 64x3 instance plus an
// 8-bit single-stage instance.
module tb_flopr_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] q;
  logic [1:0]  occupancy;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_d;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_q;
  logic        s_occ;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  flopr_pipe #(.N(64), .STAGES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .occupancy (occupancy)
  );

  flopr_pipe #(.N(8), .STAGES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .d         (s_d),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .q         (s_q),
    .occupancy (s_occ)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; samples, then advances one edge.
  task automatic tick();
    logic [63:0] e;
    #2;
    check("occ", 64'(occupancy), 64'(sb.size()));
    if (flush) check("flush_rdy", 64'(in_ready), 64'd0);
    if (in_valid && in_ready) sb.push_back(d);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("q", q, e);
      end
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [63:0] items [3];
  int nv;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    d = '0;
    out_ready = 1'b0;
    s_flush = 1'b0;
    s_in_valid = 1'b0;
    s_d = '0;
    s_out_ready = 1'b0;
    #2;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_q", q, 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ir", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming, back-to-back
    items[0] = 64'h12345678;
    items[1] = 64'h01ea7a55;
    items[2] = 64'h00011001;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      d = (i < 3) ? items[i] : 64'h0;
      #1;
      check("str_ov", 64'(out_valid), 64'(i >= 3));
      if (i < 3) check("str_ir", 64'(in_ready), 64'd1);
      tick();
    end
    check("str_empty", 64'(sb.size()), 64'd0);

    // Back-pressure
    items[0] = 64'hA0A0_0001;
    items[1] = 64'hB1B1_0002;
    items[2] = 64'hC2C2_0003;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      d = 64'hF000 + 64'(i);
      if (i < 3) d = items[i];
      tick();
    end
    check("bp_acc", 64'(sb.size()), 64'd3);
    #1;
    check("bp_ir", 64'(in_ready), 64'd0);
    check("bp_occ", 64'(occupancy), 64'd3);
    check("bp_q", q, items[0]);
    out_ready = 1'b1;
    #1;
    check("bp_rel_ir", 64'(in_ready), 64'd1);
    drain();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; d = 64'hAAAA; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; d = 64'hBBBB; tick();
    in_valid = 1'b0; tick(); tick();
    #1;
    check("bub_occ", 64'(occupancy), 64'd2);
    check("bub_ir", 64'(in_ready), 64'd1);
    check("bub_q", q, 64'hAAAA);
    check("bub_ov", 64'(out_valid), 64'd1);
    drain();

    // Flush with input offered
    items[0] = 64'h69694200;
    items[1] = 64'h48eaf54c;
    items[2] = 64'h80ecd145;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; d = items[i]; tick();
    end
    flush = 1'b1; in_valid = 1'b1; d = 64'hDEAD_BEEF; tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_ov", 64'(out_valid), 64'd0);
    check("fl_q", q, 64'd0);
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (out_valid) nv++;
      tick();
    end
    check("fl_none", 64'(nv), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; d = 64'h5500 + 64'(i); tick();
    end
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("mrst_ov", 64'(out_valid), 64'd0);
    check("mrst_q", q, 64'd0);
    check("mrst_occ", 64'(occupancy), 64'd0);
    check("mrst_ir", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (out_valid) nv++;
      tick();
    end
    check("mrst_none", 64'(nv), 64'd0);

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      d = {$urandom, $urandom};
      tick();
    end
    drain();

    // Single-stage, 8-bit
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    s_d = 8'hAB;
    @(posedge clk);
    #1;
    check("s1_ir", 64'(s_in_ready), 64'd0);
    check("s1_q", 64'(s_q), 64'hAB);
    check("s1_ov", 64'(s_out_valid), 64'd1);
    s_out_ready = 1'b1;
    s_d = 8'hCD;
    #1;
    check("s1_swap_ir", 64'(s_in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("s1_swap_q", 64'(s_q), 64'hCD);
    check("s1_occ", 64'(s_occ), 64'd1);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("s1_ov_end", 64'(s_out_valid), 64'd0);
    check("s1_q_hold", 64'(s_q), 64'hCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flopr_pipe.md
# flopr_pipe

Parametrised elastic pipeline register: a chain of `STAGES` reset-able flop stages of width `N`, each with its own valid bit, a valid/ready handshake on both ends, bubble collapsing, and a synchronous flush. It generalises the single-stage `flopr` used between datapath stages of the processor. It sits between pipeline stages where a stage must stall (back-pressure) or be squashed (branch flush) without losing or duplicating data.

## Interface
- `N`, 64, data width in bits (N ≥ 1)
- `STAGES`, 3, number of register stages (STAGES ≥ 1)
- `clk` input 1, the single clock; all state changes on its rising edge
- `reset` input 1, asynchronous, active-high; clears all state immediately
- `flush` input 1, synchronous squash of every stage
- `in_valid` input 1, upstream offers `d` this cycle
- `in_ready` output 1, pipe accepts `d` on this edge
- `d` input N, upstream data
- `out_valid` output 1, last stage holds a valid item
- `out_ready` input 1, downstream takes `q` on this edge
- `q` output N, data of the last stage
- `occupancy` output $clog2(STAGES+1), number of valid stages

## Operation
- State per stage i (0 = input side, STAGES-1 = output side): `v[i]`, `data[i]`.
- Ready chain (combinational): `rdy[STAGES] = out_ready`; `rdy[i] = ~v[i] | rdy[i+1]`.
- `in_ready = rdy[0] & ~flush`; `out_valid = v[STAGES-1]`; `q = data[STAGES-1]`.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Per edge, when `flush=0`, for each stage with `rdy[i]=1`: `v[i] <= v[i-1]` (`v[-1] = in_valid`); `data[i] <= data[i-1]` (`data[-1] = d`) only if `v[i-1]=1`, otherwise `data[i]` holds.
- Stages with `rdy[i]=0` hold `v` and `data` (stall).
- Bubble collapse: an empty stage always accepts from its predecessor, even while downstream is stalled.
- Flush (priority over all handshakes): on the edge with `flush=1`, every `v[i] <= 0` and every `data[i] <= 0`; any `in_valid` that cycle is dropped (`in_ready=0`); an output transfer that cycle still counts as consumed by downstream.
- `occupancy` = popcount of `v[]`, combinational from registered valids.
- Items leave in arrival order; none are lost, duplicated or reordered.
- `STAGES=1` degenerates to a single flopr stage with valid, handshake and flush.

## Timing
- Reset (async assert, any time, including mid-transfer): all `v=0`, `data=0`; hence `out_valid=0`, `q=0`, `occupancy=0`, `in_ready=1` (if `flush=0`) within the same cycle, with no clock edge required. Deassertion takes effect from the next rising edge.
- Latency: item accepted at edge k on an empty pipe appears with `out_valid=1` after edge k+STAGES-1 (i.e. visible in the cycle after the STAGES-th edge counting acceptance as the first).
- Throughput: one item per cycle with `out_ready=1` held.
- Full (`occupancy=STAGES`) and `out_ready=0`: `in_ready=0`. Full and `out_ready=1`: `in_ready=1`; simultaneous in/out leaves occupancy at STAGES.
- Empty: `out_valid=0`; `q` holds last drained value (0 after reset/flush).
- `in_ready` depends combinationally on `out_ready` and `flush`; no combinational path from `d` or `in_valid` to any output.
- `flush` and `reset` together: reset wins (asynchronous).

## Test plan
- Reset mid-stream: three items loaded, assert `reset` at mid-cycle -> `out_valid=0`, `q=64'h0`, `occupancy=0` before next edge; items never appear.
- Streaming: STAGES=3, `out_ready=1`, feed 64'h12345678, 64'h01ea7a55, 64'h00011001 back-to-back -> outputs the same order, first `out_valid` after 3rd edge, one per cycle, `in_ready` constantly 1.
- Back-pressure: `out_ready=0`, `in_valid=1` -> exactly 3 accepts, then `in_ready=0`, `occupancy=3`, `q=` first item held; release `out_ready` -> `in_ready=1` same cycle, all items drain in order.
- Bubble collapse: item A accepted, idle one cycle, item B, `out_ready=0` -> A at stage 2, B at stage 1 after bubbles close, `occupancy=2`, `in_ready=1`.
- Flush: pipe full of 64'h69694200/48eaf54c/80ecd145, `flush=1` with `in_valid=1` one cycle -> next cycle `occupancy=0`, `out_valid=0`, `q=0`, flushed-cycle input not stored.
- STAGES=1, N=8: 0xAB in with `out_ready=0` -> `in_ready=0` next cycle, `q=8'hAB`; then `out_ready=1`, `in_valid=1`, `d=8'hCD` -> swap in one edge, `occupancy` stays 1.
